// File: rtl/ps2_rx_pkg.sv
// Shared types and helpers for the PS/2 receive controller.
// Holds the FSM state encoding, the frame length and the timeout cycle-count helper.
package ps2_rx_pkg;

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} ps2_rx_state_t;

    localparam int PS2_FRAME_BITS = 11;

    function automatic int timeout_cycles(input longint clk_hz, input longint timeout_us);
        return int'((clk_hz / 64'd1_000_000) * timeout_us);
    endfunction

endpackage

// File: rtl/ps2_rx_fifo.sv
// First-word-fall-through scan-code FIFO: head visible on rdata whenever valid is high.
// A push into a full FIFO is dropped unless a pop happens in the same cycle.
module ps2_rx_fifo #(
    parameter  int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [7:0]    wdata,
    input  logic          pop,
    output logic [7:0]    rdata,
    output logic          valid,
    output logic [CW-1:0] count,
    output logic          drop
);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          full;
    logic          empty;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
    assign do_push = push & (~full | do_pop);
    assign drop    = push & full & ~do_pop;

    assign valid = ~empty;
    assign rdata = empty ? 8'h00 : mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/ps2_rx_ctrl.sv
// PS/2 device-to-host receiver: synchronise and filter the pads, deframe 11-bit frames,
// queue good scan codes in a FWFT FIFO and report sticky errors plus a level interrupt.
module ps2_rx_ctrl
    import ps2_rx_pkg::*;
#(
    parameter int CLK_HZ     = 100_000_000,
    parameter int FIFO_DEPTH = 8,
    parameter int FILTER_LEN = 4,
    parameter int TIMEOUT_US = 2000
) (
    input  logic                          ACLK,
    input  logic                          ARESETN,
    input  logic                          ps2_clk_i,
    input  logic                          ps2_data_i,
    input  logic                          enable,
    input  logic                          rd_en,
    output logic [7:0]                    rd_data,
    output logic                          rd_valid,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    input  logic                          err_clr,
    output logic                          err_parity,
    output logic                          err_frame,
    output logic                          err_overflow,
    output logic                          irq
);

    localparam int DATA_BITS = PS2_FRAME_BITS - 3;
    localparam int TO_CYC    = timeout_cycles(CLK_HZ, TIMEOUT_US);
    localparam int TO_W      = $clog2(TO_CYC + 1);
    localparam int FL_W      = $clog2(FILTER_LEN + 1);

    logic            ps2_clk_p0, ps2_clk_p1;
    logic            ps2_data_p0, ps2_data_p1;
    logic            clk_filt;
    logic [FL_W-1:0] filt_cnt;
    logic            fall;

    ps2_rx_state_t   state;
    logic [2:0]      bitcnt;
    logic [7:0]      shreg;
    logic            par_bit;
    logic [TO_W-1:0] to_cnt;

    logic            stop_fall, par_ok, push, timeout;
    logic            set_frame, set_parity, fifo_drop;

    // Stage p0/p1: two-flop synchronisers, idle-high after reset.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            ps2_clk_p0  <= 1'b1;
            ps2_clk_p1  <= 1'b1;
            ps2_data_p0 <= 1'b1;
            ps2_data_p1 <= 1'b1;
        end else begin
            ps2_clk_p0  <= ps2_clk_i;
            ps2_clk_p1  <= ps2_clk_p0;
            ps2_data_p0 <= ps2_data_i;
            ps2_data_p1 <= ps2_data_p0;
        end
    end

    // Glitch filter: the filtered clock follows only after FILTER_LEN differing samples.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            clk_filt <= 1'b1;
            filt_cnt <= '0;
            fall     <= 1'b0;
        end else begin
            fall <= 1'b0;
            if (ps2_clk_p1 == clk_filt) begin
                filt_cnt <= '0;
            end else if (filt_cnt == FL_W'(FILTER_LEN - 1)) begin
                clk_filt <= ps2_clk_p1;
                filt_cnt <= '0;
                fall     <= ~ps2_clk_p1;
            end else begin
                filt_cnt <= filt_cnt + 1'b1;
            end
        end
    end

    assign stop_fall  = enable & fall & (state == STOP);
    assign par_ok     = ^{shreg, par_bit};
    assign push       = stop_fall & ps2_data_p1 & par_ok;
    assign timeout    = enable & ~fall & (state != IDLE) & (to_cnt == TO_W'(TO_CYC - 1));
    assign set_parity = stop_fall & ~par_ok;
    assign set_frame  = timeout | stop_fall & ~ps2_data_p1
                      | (enable & fall & (state == IDLE) & ps2_data_p1);

    // Frame FSM: every transition is on a filtered falling edge, except timeout.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state  <= IDLE;
            bitcnt <= '0;
            to_cnt <= '0;
        end else if (!enable || timeout) begin
            state  <= IDLE;
            to_cnt <= '0;
        end else begin
            if (state != IDLE) to_cnt <= fall ? '0 : to_cnt + 1'b1;
            if (fall) begin
                case (state)
                    IDLE: if (!ps2_data_p1) begin
                        state  <= DATA;
                        bitcnt <= '0;
                        to_cnt <= '0;
                    end
                    DATA: begin
                        bitcnt <= bitcnt + 1'b1;
                        if (bitcnt == 3'(DATA_BITS - 1)) state <= PARITY;
                    end
                    PARITY:  state <= STOP;
                    default: state <= IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge ACLK) begin
        if (fall && state == DATA)   shreg   <= {ps2_data_p1, shreg[7:1]};
        if (fall && state == PARITY) par_bit <= ps2_data_p1;
    end

    // Sticky errors: a new set in the same cycle as err_clr takes priority.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            err_parity   <= 1'b0;
            err_frame    <= 1'b0;
            err_overflow <= 1'b0;
        end else begin
            err_parity   <= set_parity | (err_parity   & ~err_clr);
            err_frame    <= set_frame  | (err_frame    & ~err_clr);
            err_overflow <= fifo_drop  | (err_overflow & ~err_clr);
        end
    end

    ps2_rx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (ACLK),
        .rst_n (ARESETN),
        .push  (push),
        .wdata (shreg),
        .pop   (rd_en),
        .rdata (rd_data),
        .valid (rd_valid),
        .count (fifo_count),
        .drop  (fifo_drop)
    );

    assign irq = rd_valid | err_parity | err_frame | err_overflow;

endmodule

// File: tb/tb_ps2_rx_ctrl.sv
// Self-checking bench for ps2_rx_ctrl: PS/2 frames driven on the pads, outputs compared
// every settled cycle against a queue-based model of the received scan codes and errors.
module tb_ps2_rx_ctrl;

    localparam int CLK_HZ  = 1_000_000;
    localparam int DEPTH   = 8;
    localparam int FL      = 4;
    localparam int TUS     = 100;
    localparam int TO_CYC  = CLK_HZ / 1_000_000 * TUS;
    localparam int HP      = 10;
    localparam int SETTLE  = 14;

    logic       aclk = 1'b0;
    logic       rst_n;
    logic       ps2_clk, ps2_data, enable, rd_en, err_clr;
    logic [7:0] rd_data;
    logic       rd_valid, err_parity, err_frame, err_overflow, irq;
    logic [$clog2(DEPTH):0] fifo_count;

    ps2_rx_ctrl #(.CLK_HZ(CLK_HZ), .FIFO_DEPTH(DEPTH), .FILTER_LEN(FL), .TIMEOUT_US(TUS)) dut (
        .ACLK(aclk), .ARESETN(rst_n), .ps2_clk_i(ps2_clk), .ps2_data_i(ps2_data),
        .enable(enable), .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid),
        .fifo_count(fifo_count), .err_clr(err_clr), .err_parity(err_parity),
        .err_frame(err_frame), .err_overflow(err_overflow), .irq(irq)
    );

    always #5 aclk = ~aclk;

    // Reference model: received bytes and sticky error flags.
    logic [7:0] exp_q[$];
    logic       exp_par, exp_frm, exp_ovf;
    int         cyc;
    int         hold_until;
    int         n_checks;
    int         n_fail;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 30)
                $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge aclk);
    endtask

    function automatic logic odd_p(input logic [7:0] b);
        return ~(^b);
    endfunction

    task automatic model_frame(input logic [7:0] b, input logic p, input logic stp);
        hold_until = cyc + SETTLE;
        if (stp && (^{b, p})) begin
            if (exp_q.size() == DEPTH) exp_ovf = 1'b1;
            else exp_q.push_back(b);
        end else begin
            if (!stp)       exp_frm = 1'b1;
            if (!(^{b, p})) exp_par = 1'b1;
        end
    endtask

    // One full frame; glitch_bit >= 0 adds a 2-cycle low pulse in that bit's high phase.
    task automatic send_frame(input logic [7:0] b, input logic p, input logic stp,
                              input int glitch_bit);
        logic [10:0] f;
        f = {stp, p, b, 1'b0};
        for (int i = 0; i < 11; i++) begin
            ps2_data = f[i];
            wait_cyc(3);
            if (i == glitch_bit) begin
                ps2_clk = 1'b0;
                wait_cyc(2);
                ps2_clk = 1'b1;
                wait_cyc(HP - 5);
            end else begin
                wait_cyc(HP - 3);
            end
            ps2_clk = 1'b0;
            if (i == 10) model_frame(b, p, stp);
            wait_cyc(HP);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
        wait_cyc(HP);
    endtask

    task automatic send_bits(input int nbits);
        for (int i = 0; i < nbits; i++) begin
            ps2_data = (i == 0) ? 1'b0 : 1'($urandom_range(0, 1));
            wait_cyc(HP);
            ps2_clk = 1'b0;
            wait_cyc(HP);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
    endtask

    task automatic do_pop();
        @(negedge aclk);
        hold_until = cyc + 2;
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        rd_en = 1'b1;
        @(negedge aclk);
        rd_en = 1'b0;
        wait_cyc(2);
    endtask

    task automatic do_clr();
        @(negedge aclk);
        hold_until = cyc + 2;
        exp_par = 1'b0;
        exp_frm = 1'b0;
        exp_ovf = 1'b0;
        err_clr = 1'b1;
        @(negedge aclk);
        err_clr = 1'b0;
        wait_cyc(2);
    endtask

    task automatic drain_clear();
        while (exp_q.size() > 0) do_pop();
        do_pop();
        do_clr();
    endtask

    initial begin
        rst_n = 1'b0; ps2_clk = 1'b1; ps2_data = 1'b1;
        enable = 1'b1; rd_en = 1'b0; err_clr = 1'b0;
        exp_par = 1'b0; exp_frm = 1'b0; exp_ovf = 1'b0;
        cyc = 0; hold_until = 1_000_000; n_checks = 0; n_fail = 0;

        fork
            forever begin
                @(posedge aclk);
                cyc++;
            end
            forever begin
                @(negedge aclk);
                if (rst_n && cyc >= hold_until) begin
                    check("rd_valid", 32'(rd_valid), 32'(exp_q.size() != 0));
                    check("fifo_count", 32'(fifo_count), 32'(exp_q.size()));
                    check("rd_data", 32'(rd_data), (exp_q.size() != 0) ? 32'(exp_q[0]) : 32'h0);
                    check("err_parity", 32'(err_parity), 32'(exp_par));
                    check("err_frame", 32'(err_frame), 32'(exp_frm));
                    check("err_overflow", 32'(err_overflow), 32'(exp_ovf));
                    check("irq", 32'(irq), 32'((exp_q.size() != 0) | exp_par | exp_frm | exp_ovf));
                end
            end
        join_none

        wait_cyc(4);
        check("reset rd_valid", 32'(rd_valid), 0);
        check("reset rd_data", 32'(rd_data), 0);
        check("reset irq", 32'(irq), 0);
        @(negedge aclk);
        rst_n = 1'b1;
        hold_until = cyc + 1;
        wait_cyc(10);

        // 1: good 0x1C, then one pop
        send_frame(8'h1C, 1'b0, 1'b1, -1);
        check("t1 rd_data", 32'(rd_data), 32'h1C);
        check("t1 count", 32'(fifo_count), 1);
        check("t1 rd_valid", 32'(rd_valid), 1);
        do_pop();
        check("t1 count after pop", 32'(fifo_count), 0);

        // 2: parity error, then clear
        send_frame(8'h1C, 1'b1, 1'b1, -1);
        check("t2 err_parity", 32'(err_parity), 1);
        check("t2 irq", 32'(irq), 1);
        check("t2 count", 32'(fifo_count), 0);
        do_clr();
        check("t2 irq cleared", 32'(irq), 0);

        // 3: overflow with nine frames, then ordered pops
        for (int i = 1; i <= 9; i++) send_frame(8'(i), odd_p(8'(i)), 1'b1, -1);
        check("t3 count", 32'(fifo_count), 8);
        check("t3 err_overflow", 32'(err_overflow), 1);
        for (int i = 1; i <= 8; i++) begin
            check("t3 pop order", 32'(rd_data), 32'(i));
            do_pop();
        end
        drain_clear();

        // 4: partial frame then idle beyond the timeout
        send_bits(4);
        hold_until = cyc + TO_CYC + 30;
        exp_frm = 1'b1;
        wait_cyc(TO_CYC + 40);
        check("t4 err_frame", 32'(err_frame), 1);
        send_frame(8'hF0, 1'b1, 1'b1, -1);
        check("t4 rd_data", 32'(rd_data), 32'hF0);
        drain_clear();

        // 5: clock glitches in IDLE and mid-byte
        ps2_clk = 1'b0; wait_cyc(2); ps2_clk = 1'b1; wait_cyc(HP);
        send_frame(8'h1C, 1'b0, 1'b1, 4);
        check("t5 rd_data", 32'(rd_data), 32'h1C);
        check("t5 no error", 32'(err_frame | err_parity), 0);
        drain_clear();

        // Falling edge with data high in IDLE is a bad start bit
        ps2_data = 1'b1; wait_cyc(HP);
        ps2_clk = 1'b0;
        hold_until = cyc + SETTLE; exp_frm = 1'b1;
        wait_cyc(HP); ps2_clk = 1'b1; wait_cyc(HP);
        check("bad start err_frame", 32'(err_frame), 1);
        drain_clear();

        // enable=0 mid-frame discards silently; next frame is received
        send_bits(4);
        @(negedge aclk); enable = 1'b0;
        send_bits(7);
        wait_cyc(HP);
        @(negedge aclk); enable = 1'b1;
        wait_cyc(HP);
        send_frame(8'h33, 1'b1, 1'b1, -1);
        check("enable rd_data", 32'(rd_data), 32'h33);
        check("enable no error", 32'(err_frame), 0);
        drain_clear();

        // Randomised traffic
        for (int it = 0; it < 60; it++) begin
            int r;
            logic [7:0] b;
            r = $urandom_range(0, 9);
            b = 8'($urandom);
            if (r <= 5)
                send_frame(b, ($urandom_range(0, 4) == 0) ? ~odd_p(b) : odd_p(b),
                           ($urandom_range(0, 9) != 0), -1);
            else if (r <= 8) do_pop();
            else do_clr();
        end

        // 6: reset mid-frame
        send_frame(8'h11, 1'b1, 1'b1, -1);
        send_bits(5);
        @(negedge aclk);
        hold_until = cyc + 100_000;
        #2 rst_n = 1'b0;
        exp_q.delete(); exp_par = 1'b0; exp_frm = 1'b0; exp_ovf = 1'b0;
        #1;
        check("t6 rd_valid", 32'(rd_valid), 0);
        check("t6 count", 32'(fifo_count), 0);
        check("t6 rd_data", 32'(rd_data), 0);
        check("t6 irq", 32'(irq | err_frame | err_parity | err_overflow), 0);
        ps2_clk = 1'b1; ps2_data = 1'b1;
        wait_cyc(5);
        rst_n = 1'b1;
        wait_cyc(10);
        hold_until = cyc + 1;
        send_frame(8'h5A, 1'b1, 1'b1, -1);
        check("t6 rd_data", 32'(rd_data), 32'h5A);
        check("t6 count after", 32'(fifo_count), 1);
        wait_cyc(5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
